// File: rtl/fpu_seq_ctrl.sv
// Sequencer between decode and a multi-cycle FP datapath: accepts OP-FP instructions,
// launches one op at a time, waits for done (bounded by TIMEOUT), and strobes writeback.
module fpu_seq_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic        flush,
  input  logic        fpu_done,
  output logic        inst_ready,
  output logic        fpu_start,
  output logic [2:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic        fpu_kill,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        busy,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        op_fp, legal, accept, done_eff, cnt_hit;
  logic [2:0]  op_dec;
  logic        unused_bits;

  assign unused_bits = ^{inst[26:15], inst[1:0]};

  assign op_fp    = (inst[6:2] == 5'b10100);
  assign accept   = inst_valid && inst_ready && op_fp;
  // A done seen alongside the launch pulse belongs to nothing we issued.
  assign done_eff = fpu_done && !fpu_start;
  assign cnt_hit  = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    legal  = 1'b1;
    op_dec = 3'd0;
    case (inst[31:27])
      5'b00000: op_dec = 3'd0;
      5'b00001: op_dec = 3'd1;
      5'b00010: op_dec = 3'd2;
      5'b00011: op_dec = 3'd3;
      5'b01011: op_dec = 3'd4;
      default:  legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush beats done, done beats timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && legal) state_nxt = BUSY;
      BUSY: begin
        if (flush)         state_nxt = IDLE;
        else if (done_eff) state_nxt = WB;
        else if (cnt_hit)  state_nxt = IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    inst_ready = (state == IDLE) && !flush && !rst;
    wb_valid   = (state == WB) && !flush;
    timeout    = (state == BUSY) && !flush && !done_eff && cnt_hit;
    fpu_kill   = ((state != IDLE) && flush) || timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fpu_start <= 1'b0;
      illegal   <= 1'b0;
      fpu_op    <= '0;
      fpu_rm    <= '0;
      wb_rd     <= '0;
    end else begin
      fpu_start <= accept && legal;
      illegal   <= accept && !legal;
      if (accept && legal) begin
        cnt    <= '0;
        fpu_op <= op_dec;
        fpu_rm <= inst[14:12];
        wb_rd  <= inst[11:7];
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Scoreboard bench: a time-based transaction model predicts output pulses into a queue,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_fpu_seq_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_valid = 1'b0, flush = 1'b0, fpu_done = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_ready, fpu_start, fpu_kill, wb_valid, busy, illegal, timeout;
  logic [2:0]  fpu_op, fpu_rm;
  logic [4:0]  wb_rd;

  fpu_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .flush(flush),
    .fpu_done(fpu_done), .inst_ready(inst_ready), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_kill(fpu_kill), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .busy(busy), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 start, 1 wb, 2 kill, 3 timeout, 4 illegal
  typedef struct { int cyc; int kind; int data; } ev_t;
  ev_t evq[$];
  int errors = 0, checks = 0;

  // model: 0 free, 1 op in flight, 2 writing back
  int       mode = 0, t_acc = 0;
  bit [2:0] m_op, m_rm;
  bit [4:0] m_rd;
  bit       exp_busy = 0, exp_ready = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int c, int k, int d);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d;
    evq.push_back(e);
  endtask

  task automatic ev_check(string name, int kind, int data);
    ev_t e;
    if (evq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got unexpected pulse, expected none (cycle %0d)", name, cyc);
    end else begin
      e = evq.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_cycle"}, cyc, e.cyc);
      chk({name, "_data"}, data, e.data);
    end
  endtask

  function automatic logic [31:0] mk(logic [4:0] f5, logic [2:0] rm, logic [4:0] rd);
    return {f5, 2'b00, 5'd2, 5'd1, rm, rd, 7'h53};
  endfunction

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic step(bit iv, logic [31:0] in, bit fl, bit dn);
    int  nmode;
    bit  ok;
    bit [2:0] op;
    @(posedge clk); #1;
    inst_valid = iv; inst = in; flush = fl; fpu_done = dn;
    exp_busy  = (mode != 0);
    exp_ready = (mode == 0) && !fl;
    nmode = mode;
    case (mode)
      0: if (iv && !fl && in[6:2] == 5'b10100) begin
        ok = 1; op = 0;
        case (in[31:27])
          5'd0, 5'd1, 5'd2, 5'd3: op = in[29:27];
          5'd11:                  op = 3'd4;
          default:                ok = 0;
        endcase
        if (ok) begin
          nmode = 1; t_acc = cyc;
          m_op = op; m_rm = in[14:12]; m_rd = in[11:7];
          push(cyc + 1, 0, int'({m_op, m_rm, m_rd}));
        end else push(cyc + 1, 4, 0);
      end
      1: begin
        if (fl) begin push(cyc, 2, 0); nmode = 0; end
        else if (dn && cyc != t_acc + 1) nmode = 2;
        else if (cyc - t_acc == TO) begin push(cyc, 2, 0); push(cyc, 3, 0); nmode = 0; end
      end
      default: begin
        if (fl) push(cyc, 2, 0);
        else    push(cyc, 1, int'(m_rd));
        nmode = 0;
      end
    endcase
    mode = nmode;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 32'h0, 0, 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, fpu_start, 0);
    chk({tag, "_kill"}, fpu_kill, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_fpu_op"}, fpu_op, 0);
    chk({tag, "_fpu_rm"}, fpu_rm, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_inst_ready"}, inst_ready, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, exp_busy);
      chk("inst_ready", inst_ready, exp_ready);
      if (fpu_start) ev_check("fpu_start", 0, int'({fpu_op, fpu_rm, wb_rd}));
      if (wb_valid)  ev_check("wb_valid", 1, int'(wb_rd));
      if (fpu_kill)  ev_check("fpu_kill", 2, 0);
      if (timeout)   ev_check("timeout", 3, 0);
      if (illegal)   ev_check("illegal", 4, 0);
    end
  end

  initial begin
    logic [31:0] r_inst;
    logic [4:0]  f5;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;
    exp_ready = 1;

    // fadd.s x0: done two cycles after accept, then a done on the launch cycle is ignored
    step(1, 32'h00208053, 0, 0); idle(1); step(0, 0, 0, 1); idle(2);
    step(1, 32'h00208053, 0, 0); step(0, 0, 0, 1); idle(1); step(0, 0, 0, 1); idle(2);
    // fdiv.s rd=5, done withheld until timeout
    step(1, mk(5'd3, 3'd1, 5'd5), 0, 0); idle(TO + 3);
    // illegal funct5
    step(1, mk(5'h1f, 3'd0, 5'd3), 0, 0); idle(2);
    // flush together with done in BUSY, flush in WB, flush in IDLE
    step(1, mk(5'd1, 3'd2, 5'd7), 0, 0); idle(1); step(0, 0, 1, 1); idle(2);
    step(1, mk(5'd11, 3'd3, 5'd9), 0, 0); idle(1); step(0, 0, 0, 1); step(0, 0, 1, 0); idle(1);
    step(1, 32'h00208053, 1, 0); idle(1);
    // back-to-back fmul.s with inst_valid held
    repeat (16) step(1, mk(5'd2, 3'd4, 5'd17), 0, 1);
    idle(3);
    // reset mid-BUSY
    step(1, mk(5'd3, 3'd0, 5'd12), 0, 0); idle(3);
    @(posedge clk); #1;
    rst = 1'b1; inst_valid = 0; flush = 0; fpu_done = 0;
    #1 chk_all_zero("mid_busy_rst");
    chk("queue_empty_at_rst", evq.size(), 0);
    evq.delete();
    mode = 0; exp_busy = 0; exp_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step(1, 32'h00208053, 0, 0); idle(1); step(0, 0, 0, 1); idle(2);

    // randomized traffic
    repeat (1500) begin
      case ($urandom_range(0, 7))
        0: f5 = 5'd0;  1: f5 = 5'd1;  2: f5 = 5'd2;  3: f5 = 5'd3;
        4: f5 = 5'd11; 5: f5 = 5'd2;  default: f5 = 5'($urandom);
      endcase
      r_inst = mk(f5, 3'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) r_inst = 32'h00000013 | (32'($urandom_range(0, 31)) << 7);
      step($urandom_range(0, 3) != 0, r_inst, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0);
    end
    idle(TO + 4);
    chk("queue_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_seq_ctrl.md
FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum BUSY cycles to wait for fpu_done, legal range 4..255.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port inst_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have port inst  input  32  RV32 instruction word.
REQ-006 SHALL have port flush  input  1  pipeline flush; aborts any in-flight FP op.
REQ-007 SHALL have port fpu_done  input  1  FP datapath result ready.
REQ-008 SHALL have port inst_ready  output  1  controller can accept an instruction.
REQ-009 SHALL have port fpu_start  output  1  one-cycle launch pulse to FP datapath.
REQ-010 SHALL have port fpu_op  output  3  operation: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt.
REQ-011 SHALL have port fpu_rm  output  3  rounding mode, inst[14:12] of the accepted op.
REQ-012 SHALL have port fpu_kill  output  1  one-cycle abort pulse to FP datapath.
REQ-013 SHALL have port wb_valid  output  1  one-cycle writeback strobe.
REQ-014 SHALL have port wb_rd  output  5  destination register, inst[11:7] of the accepted op.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE; drives pipeline stall.
REQ-016 SHALL have ports illegal, timeout  output  1 each  one-cycle error pulses.

Function
REQ-017 SHALL implement states IDLE, BUSY, WB; inst_ready = (state==IDLE) && !flush.
REQ-018 SHALL accept an instruction when inst_valid && inst_ready && inst[6:2]==5'b10100 (OP-FP); other opcodes are consumed with no action and no output.
REQ-019 SHALL decode funct5 = inst[31:27]: 00000 add, 00001 sub, 00010 mul, 00011 div, 01011 sqrt; any other funct5 pulses illegal the next cycle and state stays IDLE.
REQ-020 SHALL, on a legal accept, latch fpu_op, fpu_rm and wb_rd, enter BUSY next cycle and assert fpu_start in exactly that first BUSY cycle.
REQ-021 SHALL hold fpu_op, fpu_rm and wb_rd stable from accept until the next accept.
REQ-022 SHALL ignore fpu_done in the cycle fpu_start is high and in IDLE/WB.
REQ-023 SHALL, on fpu_done in BUSY, move to WB; wb_valid high for exactly the one WB cycle, then IDLE.
REQ-024 SHALL keep an 8-bit BUSY cycle counter, cleared on BUSY entry; if it reaches TIMEOUT-1 without fpu_done, pulse timeout and fpu_kill and enter IDLE next cycle.
REQ-025 SHALL give fpu_done priority over timeout in the same cycle.
REQ-026 SHALL, on flush in BUSY or WB, pulse fpu_kill, suppress wb_valid and enter IDLE next cycle; flush has priority over fpu_done and timeout.
REQ-027 SHALL treat flush in IDLE as blocking acceptance that cycle only; no kill pulse.
REQ-028 SHALL have minimum issue-to-writeback latency of 3 cycles (accept edge, fpu_start cycle, done cycle, WB cycle).

Reset
REQ-029 SHALL, on rst, immediately enter IDLE and drive fpu_start, fpu_kill, wb_valid, illegal, timeout, busy to 0, fpu_op, fpu_rm, wb_rd to 0 and the counter to 0.
REQ-030 SHALL not emit fpu_kill for an op aborted by reset; the datapath is reset by the same rst.

Verification
REQ-031 SHALL cover fadd.s (inst=32'h00208053, rd=0): accept, fpu_start next cycle with fpu_op=0, fpu_rm=0, done 2 cycles later -> wb_valid one cycle, wb_rd=0, busy low after.
REQ-032 SHALL cover fdiv.s rd=5 with done withheld -> timeout and fpu_kill pulse exactly TIMEOUT-1 cycles after BUSY entry, no wb_valid, inst_ready high next cycle.
REQ-033 SHALL cover OP-FP with funct5=11111 -> illegal pulse one cycle, fpu_start never asserted, busy stays 0.
REQ-034 SHALL cover flush and fpu_done in same BUSY cycle -> fpu_kill=1, wb_valid never asserted, IDLE next cycle.
REQ-035 SHALL cover inst_valid held with back-to-back fmul.s ops -> inst_ready low while busy, second op accepted the cycle after WB, no instruction lost or duplicated.
REQ-036 SHALL cover rst asserted mid-BUSY -> all outputs 0 asynchronously, no kill/wb pulse, normal accept after rst release.
